// File: rtl/fixed_encoder.sv
// fixed_encoder: fixed linear-predictor residual encoder for 16-bit PCM.
//
// Keeps a 4-deep history of accepted samples and, per sample, emits either
// the fixed-predictor residual of the latched order (0..4) or the verbatim
// sample while the block is still in warmup (index < order). All outputs are
// registered, so each result appears one cycle after its input.
//
// Optional feature (macro FIXED_ORDER_SEARCH_EN): five saturating
// accumulators of |residual_k| (k = 0..4) over samples with index >= 4. Two
// cycles after the last sample of a block, they select the best order.
//
// Ports:
//   iClock      in   clock, rising edge
//   iReset_n    in   asynchronous active-low reset
//   iStart      in   block-start strobe, latches iOrder (5..7 -> 4)
//   iOrder      in   [2:0] predictor order
//   iValid      in   iSample valid
//   iSample     in   [15:0] signed PCM sample
//   iLast       in   last sample of block (qualified by iValid)
//   oValid      out  oResidual/oWarmup valid
//   oResidual   out  [19:0] signed residual or sign-extended warmup sample
//   oWarmup     out  oResidual is a verbatim warmup sample
//   oBestValid  out  single-cycle pulse, oBestOrder valid
//   oBestOrder  out  [2:0] order with minimum absolute residual sum
module fixed_encoder #(
   parameter int unsigned ACC_WIDTH = 32
) (
   input  logic               iClock,
   input  logic               iReset_n,
   input  logic               iStart,
   input  logic [2:0]         iOrder,
   input  logic               iValid,
   input  logic signed [15:0] iSample,
   input  logic               iLast,
   output logic               oValid,
   output logic signed [19:0] oResidual,
   output logic               oWarmup,
   output logic               oBestValid,
   output logic [2:0]         oBestOrder
);

   logic signed [15:0] x1_q, x2_q, x3_q, x4_q;
   logic [2:0]         n_q, n_d;
   logic [2:0]         order_q, order_d;
   logic [2:0]         ord_eff, n_eff;
   logic               valid_q, warm_q, warm_d;
   logic signed [19:0] resid_q, resid_d;
   logic signed [19:0] s, a1, a2, a3, a4;
   logic signed [19:0] r0, r1, r2, r3, r4;

   // A start strobe takes effect in its own cycle: a coincident sample is
   // index 0 of the new block under the new order.
   always_comb begin
      ord_eff = iStart ? ((iOrder > 3'd4) ? 3'd4 : iOrder) : order_q;
      n_eff   = iStart ? 3'd0 : n_q;
   end

   // All terms are widened to 20 bits first; the final results fit, so any
   // intermediate wrap cancels out in two's-complement arithmetic.
   always_comb begin
      s  = 20'(iSample);
      a1 = 20'(x1_q);
      a2 = 20'(x2_q);
      a3 = 20'(x3_q);
      a4 = 20'(x4_q);
      r0 = s;
      r1 = s - a1;
      r2 = s - (a1 <<< 1) + a2;
      r3 = s - (a1 <<< 1) - a1 + (a2 <<< 1) + a2 - a3;
      r4 = s - (a1 <<< 2) + (a2 <<< 2) + (a2 <<< 1) - (a3 <<< 2) + a4;
   end

   always_comb begin
      warm_d  = (n_eff < ord_eff);
      resid_d = r4;
      unique case (ord_eff)
         3'd0:    resid_d = r0;
         3'd1:    resid_d = r1;
         3'd2:    resid_d = r2;
         3'd3:    resid_d = r3;
         default: resid_d = r4;
      endcase
      if (warm_d) resid_d = s;
      order_d = ord_eff;
      n_d     = n_eff;
      if (iValid) n_d = (n_eff >= 3'd4) ? 3'd4 : n_eff + 3'd1;
   end

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         x1_q    <= '0;
         x2_q    <= '0;
         x3_q    <= '0;
         x4_q    <= '0;
         n_q     <= '0;
         order_q <= '0;
         valid_q <= 1'b0;
         resid_q <= '0;
         warm_q  <= 1'b0;
      end else begin
         n_q     <= n_d;
         order_q <= order_d;
         valid_q <= iValid;
         if (iValid) begin
            resid_q <= resid_d;
            warm_q  <= warm_d;
            x1_q    <= iSample;
            x2_q    <= x1_q;
            x3_q    <= x2_q;
            x4_q    <= x3_q;
         end
      end
   end

   assign oValid    = valid_q;
   assign oResidual = resid_q;
   assign oWarmup   = warm_q;

`ifdef FIXED_ORDER_SEARCH_EN
   localparam int unsigned SW = (ACC_WIDTH > 20) ? ACC_WIDTH + 1 : 21;
   localparam logic [SW-1:0] ACC_MAX = SW'({ACC_WIDTH{1'b1}});

   logic [ACC_WIDTH-1:0] acc_q [5];
   logic [ACC_WIDTH-1:0] acc_d [5];
   logic [19:0]          mag   [5];
   logic [SW-1:0]        sum;
   logic                 last_q;
   logic                 best_valid_q;
   logic [2:0]           best_q, best_d;

   always_comb begin
      mag[0] = r0[19] ? 20'(-r0) : r0;
      mag[1] = r1[19] ? 20'(-r1) : r1;
      mag[2] = r2[19] ? 20'(-r2) : r2;
      mag[3] = r3[19] ? 20'(-r3) : r3;
      mag[4] = r4[19] ? 20'(-r4) : r4;
      sum    = '0;
      for (int unsigned k = 0; k < 5; k++) begin
         sum      = SW'(acc_q[k]) + SW'(mag[k]);
         acc_d[k] = (sum > ACC_MAX) ? '1 : ACC_WIDTH'(sum);
      end
   end

   // Strict less-than keeps the lowest order on ties.
   always_comb begin
      best_d = 3'd0;
      for (int unsigned k = 1; k < 5; k++) begin
         if (acc_q[k] < acc_q[best_d]) best_d = 3'(k);
      end
   end

   always_ff @(posedge iClock or negedge iReset_n) begin
      if (!iReset_n) begin
         for (int unsigned k = 0; k < 5; k++) acc_q[k] <= '0;
         last_q       <= 1'b0;
         best_valid_q <= 1'b0;
         best_q       <= '0;
      end else begin
         if (iStart) begin
            for (int unsigned k = 0; k < 5; k++) acc_q[k] <= '0;
         end else if (iValid && (n_eff >= 3'd4)) begin
            for (int unsigned k = 0; k < 5; k++) acc_q[k] <= acc_d[k];
         end
         // One cycle lets the last sample land in the sums before selection.
         last_q       <= iValid & iLast;
         best_valid_q <= last_q;
         if (last_q) best_q <= best_d;
      end
   end

   assign oBestValid = best_valid_q;
   assign oBestOrder = best_q;
`else
   logic unused_search;
   assign unused_search = iLast | (ACC_WIDTH == 0);
   assign oBestValid    = 1'b0;
   assign oBestOrder    = 3'd0;
`endif

endmodule

// File: tb/tb_fixed_encoder.sv
module tb_fixed_encoder;

   logic               iClock = 1'b0;
   logic               iReset_n;
   logic               iStart;
   logic [2:0]         iOrder;
   logic               iValid;
   logic signed [15:0] iSample;
   logic               iLast;
   logic               oValid;
   logic signed [19:0] oResidual;
   logic               oWarmup;
   logic               oBestValid;
   logic [2:0]         oBestOrder;

   int compared   = 0;
   int mismatched = 0;

   fixed_encoder #(.ACC_WIDTH(32)) dut (
      .iClock     (iClock),
      .iReset_n   (iReset_n),
      .iStart     (iStart),
      .iOrder     (iOrder),
      .iValid     (iValid),
      .iSample    (iSample),
      .iLast      (iLast),
      .oValid     (oValid),
      .oResidual  (oResidual),
      .oWarmup    (oWarmup),
      .oBestValid (oBestValid),
      .oBestOrder (oBestOrder)
   );

   always #5 iClock = ~iClock;

   // Applies one cycle of inputs, then returns 1 time unit after the edge.
   task automatic drive(input logic st, input logic [2:0] ord, input logic v,
                        input int smp, input logic lst);
      iStart  = st;
      iOrder  = ord;
      iValid  = v;
      iSample = 16'(smp);
      iLast   = lst;
      @(posedge iClock);
      #1;
      iStart = 1'b0;
      iValid = 1'b0;
      iLast  = 1'b0;
   endtask

   task automatic test_reset;
      iReset_n = 1'b0;
      iStart = 0; iOrder = 0; iValid = 0; iSample = 0; iLast = 0;
      #12;
      compared++;
      if ({oValid, oResidual, oWarmup, oBestValid, oBestOrder} !== 26'd0) begin
         mismatched++;
         $display("FAIL reset_state got %h exp 0",
                  {oValid, oResidual, oWarmup, oBestValid, oBestOrder});
      end
      #1 iReset_n = 1'b1;
      @(posedge iClock); #1;
   endtask

   task automatic test_order1;
      int smp [4] = '{10, 12, 15, 11};
      int exp [4] = '{10, 2, 3, -4};
      logic ew [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 4; i++) begin
         drive(i == 0, 3'd1, 1'b1, smp[i], 1'b0);
         compared++;
         if (oValid !== 1'b1 || oResidual !== 20'(exp[i]) || oWarmup !== ew[i]) begin
            mismatched++;
            $display("FAIL order1[%0d] got v=%b r=%0d w=%b exp v=1 r=%0d w=%b",
                     i, oValid, oResidual, oWarmup, exp[i], ew[i]);
         end
      end
      drive(1'b0, 3'd1, 1'b0, 0, 1'b0);
      compared++;
      if (oValid !== 1'b0 || oResidual !== -20'sd4 || oWarmup !== 1'b0) begin
         mismatched++;
         $display("FAIL order1_hold got v=%b r=%0d w=%b exp v=0 r=-4 w=0",
                  oValid, oResidual, oWarmup);
      end
   endtask

   task automatic test_order2;
      int smp [5] = '{1, 4, 9, 16, 25};
      int exp [5] = '{1, 4, 2, 2, 2};
      logic ew [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         drive(i == 0, 3'd2, 1'b1, smp[i], 1'b0);
         compared++;
         if (oValid !== 1'b1 || oResidual !== 20'(exp[i]) || oWarmup !== ew[i]) begin
            mismatched++;
            $display("FAIL order2[%0d] got v=%b r=%0d w=%b exp v=1 r=%0d w=%b",
                     i, oValid, oResidual, oWarmup, exp[i], ew[i]);
         end
      end
   endtask

   // x - 4x1 + 6x2 - 4x3 + x4 at the extremes, no wrap.
   task automatic test_order4;
      int smp [7] = '{0, 0, 0, 0, 32767, -32768, 32767};
      int exp [7] = '{0, 0, 0, 0, 32767, -163836, 360441};
      logic ew [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         drive(i == 0, 3'd4, 1'b1, smp[i], 1'b0);
         compared++;
         if (oValid !== 1'b1 || oResidual !== 20'(exp[i]) || oWarmup !== ew[i]) begin
            mismatched++;
            $display("FAIL order4[%0d] got v=%b r=%0d w=%b exp v=1 r=%0d w=%b",
                     i, oValid, oResidual, oWarmup, exp[i], ew[i]);
         end
      end
   endtask

   // Order 7 acts as 4; iOrder changes after the start strobe are ignored.
   task automatic test_order_clamp;
      int smp [6] = '{5, 5, 5, 5, 5, 8};
      int exp [6] = '{5, 5, 5, 5, 0, 3};
      logic ew [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         drive(i == 0, (i == 0) ? 3'd7 : 3'd0, 1'b1, smp[i], 1'b0);
         compared++;
         if (oResidual !== 20'(exp[i]) || oWarmup !== ew[i]) begin
            mismatched++;
            $display("FAIL clamp[%0d] got r=%0d w=%b exp r=%0d w=%b",
                     i, oResidual, oWarmup, exp[i], ew[i]);
         end
      end
   endtask

   task automatic test_search;
      // Ramp: order-1 residual is 3, orders 2..4 are 0 -> tie, lowest is 2.
      for (int i = 0; i < 11; i++) drive(i == 0, 3'd1, 1'b1, 3 * i, i == 10);
      compared++;
      if (oBestValid !== 1'b0) begin
         mismatched++;
         $display("FAIL search_early got bv=%b exp 0", oBestValid);
      end
      drive(1'b0, 3'd0, 1'b0, 0, 1'b0);
`ifdef FIXED_ORDER_SEARCH_EN
      compared++;
      if (oBestValid !== 1'b1 || oBestOrder !== 3'd2) begin
         mismatched++;
         $display("FAIL search_ramp got bv=%b bo=%0d exp bv=1 bo=2", oBestValid, oBestOrder);
      end
`else
      compared++;
      if (oBestValid !== 1'b0 || oBestOrder !== 3'd0) begin
         mismatched++;
         $display("FAIL search_off got bv=%b bo=%0d exp 0 0", oBestValid, oBestOrder);
      end
`endif
      drive(1'b0, 3'd0, 1'b0, 0, 1'b0);
      compared++;
      if (oBestValid !== 1'b0) begin
         mismatched++;
         $display("FAIL search_pulse_width got bv=%b exp 0", oBestValid);
      end
      // Short block of 3 samples reports order 0.
      for (int i = 0; i < 3; i++) drive(i == 0, 3'd3, 1'b1, 100 * i + 7, i == 2);
      drive(1'b0, 3'd0, 1'b0, 0, 1'b0);
      compared++;
`ifdef FIXED_ORDER_SEARCH_EN
      if (oBestValid !== 1'b1 || oBestOrder !== 3'd0) begin
         mismatched++;
         $display("FAIL search_short got bv=%b bo=%0d exp bv=1 bo=0", oBestValid, oBestOrder);
      end
`else
      if (oBestValid !== 1'b0 || oBestOrder !== 3'd0) begin
         mismatched++;
         $display("FAIL search_short_off got bv=%b bo=%0d exp 0 0", oBestValid, oBestOrder);
      end
`endif
      drive(1'b0, 3'd0, 1'b0, 0, 1'b0);
   endtask

   task automatic test_reset_mid;
      drive(1'b1, 3'd3, 1'b1, 7, 1'b0);
      drive(1'b0, 3'd3, 1'b1, 9, 1'b1);
      compared++;
      if (oValid !== 1'b1 || oResidual !== 20'sd9 || oWarmup !== 1'b1) begin
         mismatched++;
         $display("FAIL rst_pre got v=%b r=%0d w=%b exp v=1 r=9 w=1", oValid, oResidual, oWarmup);
      end
      #2 iReset_n = 1'b0;
      #1;
      compared++;
      if ({oValid, oResidual, oWarmup, oBestValid, oBestOrder} !== 26'd0) begin
         mismatched++;
         $display("FAIL rst_async got %h exp 0",
                  {oValid, oResidual, oWarmup, oBestValid, oBestOrder});
      end
      @(posedge iClock); #3;
      iReset_n = 1'b1;
      @(posedge iClock); #1;
      compared++;
      if (oBestValid !== 1'b0) begin
         mismatched++;
         $display("FAIL rst_no_best got bv=%b exp 0", oBestValid);
      end
      // No start strobe: order 0, index 0, so samples pass as plain residuals.
      drive(1'b0, 3'd2, 1'b1, 50, 1'b0);
      compared++;
      if (oValid !== 1'b1 || oResidual !== 20'sd50 || oWarmup !== 1'b0) begin
         mismatched++;
         $display("FAIL rst_after0 got v=%b r=%0d w=%b exp v=1 r=50 w=0", oValid, oResidual, oWarmup);
      end
      drive(1'b0, 3'd2, 1'b1, -60, 1'b0);
      compared++;
      if (oResidual !== -20'sd60 || oWarmup !== 1'b0) begin
         mismatched++;
         $display("FAIL rst_after1 got r=%0d w=%b exp r=-60 w=0", oResidual, oWarmup);
      end
   endtask

   // Start strobe coincident with a sample restarts warmup under the new order.
   task automatic test_midblock_start;
      int smp [6] = '{100, 200, 300, 400, 500, 600};
      int exp [6] = '{100, 200, 300, 400, 500, 0};
      logic ew [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         drive(i == 0 || i == 3, (i < 3) ? 3'd0 : ((i == 3) ? 3'd2 : 3'd0),
               1'b1, smp[i], 1'b0);
         compared++;
         if (oValid !== 1'b1 || oResidual !== 20'(exp[i]) || oWarmup !== ew[i]) begin
            mismatched++;
            $display("FAIL midstart[%0d] got v=%b r=%0d w=%b exp v=1 r=%0d w=%b",
                     i, oValid, oResidual, oWarmup, exp[i], ew[i]);
         end
      end
   endtask

   initial begin
      test_reset;
      test_order1;
      test_order2;
      test_order4;
      test_order_clamp;
      test_search;
      test_reset_mid;
      test_midblock_start;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
